// File: rtl/seq_pattern_tx_pkg.sv
// Shared constants for the serial frame transmitter and its matching detector.
// Holds the state encodings, the default sync pattern and the counter sizing helper.
package seq_pattern_tx_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  localparam int SYNC_W_DEF = 4;
  localparam logic [SYNC_W_DEF-1:0] SYNC_PAT_DEF = 4'b1001;

  function automatic int cnt_w(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = 1;
    if (a > m) m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in / serial-out register, MSB presented first.
// Load wins over shift; shifting moves the next bit into the MSB.
module piso_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] din_i,
  output logic         msb_o
);

  logic [W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i)
      sr_d = din_i;
    else if (shift_i)
      sr_d = sr_q << 1;
  end

  always_ff @(posedge clk) begin
    if (!rst)
      sr_q <= '0;
    else
      sr_q <= sr_d;
  end

  assign msb_o = sr_q[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter: sync pattern, payload MSB first, then idle gap.
// Output flops are loaded from next-state so bits leave on the edge after entry.
module seq_pattern_tx
  import seq_pattern_tx_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SYNC_W = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_W'(SYNC_PAT_DEF),
  parameter int GAP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              dout,
  output logic              dout_en,
  output logic              frame_done,
  output logic              busy
);

  localparam int CW = cnt_w(SYNC_W, DATA_W, GAP);
  localparam logic [CW-1:0] SYNC_LD = CW'(SYNC_W - 1);
  localparam logic [CW-1:0] DATA_LD = CW'(DATA_W - 1);
  localparam logic [CW-1:0] GAP_LD  = (GAP > 0) ? CW'(GAP - 1) : '0;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dout_q, dout_d;
  logic          en_q, en_d;
  logic          done_q, done_d;
  logic          load, shift, msb, last, sync_bit;

  piso_shift #(.W(DATA_W)) u_piso (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .shift_i (shift),
    .din_i   (din),
    .msb_o   (msb)
  );

  assign last = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (din_valid) begin
          state_d = ST_SYNC;
          cnt_d   = SYNC_LD;
          load    = 1'b1;
        end
      end
      ST_SYNC: begin
        if (last) begin
          state_d = ST_DATA;
          cnt_d   = DATA_LD;
          shift   = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DATA: begin
        if (!last) begin
          cnt_d = cnt_q - CW'(1);
          shift = 1'b1;
        end else if (GAP > 0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LD;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_GAP: begin
        if (last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The shift pops the bit about to be shown, so msb is the outgoing bit.
  assign sync_bit = |(SYNC_PAT & (SYNC_W'(1) << cnt_d));

  always_comb begin
    dout_d = 1'b0;
    if (shift)
      dout_d = msb;
    else if (state_d == ST_SYNC)
      dout_d = sync_bit;
    en_d   = (state_d == ST_SYNC) || (state_d == ST_DATA);
    done_d = (state_d == ST_DATA) && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  assign din_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign dout       = dout_q;
  assign dout_en    = en_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: default instance plus a 4-bit, no-gap instance.
// Stimulus pushes expected {dout, frame_done} per enabled cycle; monitors pop and compare.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din0 = '0;
  logic       val0 = 1'b0;
  logic [3:0] din1 = '0;
  logic       val1 = 1'b0;
  logic       rdy0, d0, en0, fd0, bsy0;
  logic       rdy1, d1, en1, fd1, bsy1;

  int tests = 0;
  int fails = 0;
  int en_cnt0 = 0;
  int snap;
  logic [1:0] q0[$];
  logic [1:0] q1[$];

  always #5 clk = ~clk;

  seq_pattern_tx u0 (
    .clk(clk), .rst(rst), .din(din0), .din_valid(val0),
    .din_ready(rdy0), .dout(d0), .dout_en(en0),
    .frame_done(fd0), .busy(bsy0)
  );

  seq_pattern_tx #(.DATA_W(4), .GAP(0)) u1 (
    .clk(clk), .rst(rst), .din(din1), .din_valid(val1),
    .din_ready(rdy1), .dout(d1), .dout_en(en1),
    .frame_done(fd1), .busy(bsy1)
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected frame for u0: sync 1001 then payload MSB first; keep = entries visible.
  task automatic push0(input logic [7:0] d, input int keep);
    logic [11:0] bits;
    bits = {4'b1001, d};
    for (int i = 0; i < keep; i++)
      q0.push_back({bits[11-i], (i == 11) ? 1'b1 : 1'b0});
  endtask

  task automatic push1(input logic [3:0] d);
    logic [7:0] bits;
    bits = {4'b1001, d};
    for (int i = 0; i < 8; i++)
      q1.push_back({bits[7-i], (i == 7) ? 1'b1 : 1'b0});
  endtask

  always @(negedge clk) begin
    logic [1:0] e;
    if (en0) begin
      en_cnt0++;
      tests++;
      if (q0.size() == 0) begin
        fails++;
        $display("FAIL u0_extra: got dout=%0b done=%0b expected none",
                 d0, fd0);
      end else begin
        e = q0.pop_front();
        if ({d0, fd0} !== e) begin
          fails++;
          $display("FAIL u0_bit: got %b expected %b", {d0, fd0}, e);
        end
      end
    end else if (fd0) begin
      tests++;
      fails++;
      $display("FAIL u0_stray_done: got 1 expected 0");
    end
    if (en1) begin
      tests++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL u1_extra: got dout=%0b done=%0b expected none",
                 d1, fd1);
      end else begin
        e = q1.pop_front();
        if ({d1, fd1} !== e) begin
          fails++;
          $display("FAIL u1_bit: got %b expected %b", {d1, fd1}, e);
        end
      end
    end else if (fd1) begin
      tests++;
      fails++;
      $display("FAIL u1_stray_done: got 1 expected 0");
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    @(negedge clk);
    chk("reset_state", {rdy0, d0, en0, fd0, bsy0}, 5'b10000);
    chk("reset_u1", {rdy1, d1, en1, fd1, bsy1}, 5'b10000);

    // Single frame A5, din disturbed during flight.
    din0 = 8'hA5; val0 = 1'b1; push0(8'hA5, 12);
    tick();
    val0 = 1'b0; din0 = 8'hFF;
    @(negedge clk);
    chk("a5_busy_c1", {rdy0, bsy0}, 2'b01);
    repeat (12) tick();
    @(negedge clk);
    chk("a5_gap_c13", {d0, en0, bsy0, rdy0}, 4'b0010);
    tick();
    @(negedge clk);
    chk("a5_gap_c14", {d0, en0, bsy0, rdy0}, 4'b0010);
    tick();
    @(negedge clk);
    chk("a5_ready_c15", {rdy0, bsy0}, 2'b10);

    // All-zero payload, count enabled cycles.
    snap = en_cnt0;
    din0 = 8'h00; val0 = 1'b1; push0(8'h00, 12);
    tick();
    val0 = 1'b0;
    repeat (14) tick();
    @(negedge clk);
    chk("zero_en_count", en_cnt0 - snap, 12);
    chk("zero_ready_c15", rdy0, 1'b1);

    // Back-to-back with valid held high.
    din0 = 8'h3C; val0 = 1'b1; push0(8'h3C, 12); push0(8'h81, 12);
    tick();
    din0 = 8'h81;
    repeat (14) tick();
    @(negedge clk);
    chk("b2b_ready_c15", {rdy0, en0}, 2'b10);
    tick();
    val0 = 1'b0;
    @(negedge clk);
    chk("b2b_sync_c16", {en0, d0, rdy0}, 3'b110);
    repeat (14) tick();
    @(negedge clk);
    chk("b2b_idle", rdy0, 1'b1);

    // Reset during payload bit 2.
    din0 = 8'hC3; val0 = 1'b1; push0(8'hC3, 6);
    tick();
    val0 = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_mid_outs", {d0, en0, bsy0, fd0}, 4'b0000);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", rdy0, 1'b1);
    chk("rst_mid_drained", q0.size(), 0);
    din0 = 8'hFF; val0 = 1'b1; push0(8'hFF, 12);
    tick();
    val0 = 1'b0;
    repeat (14) tick();
    @(negedge clk);
    chk("ff_ready_c15", rdy0, 1'b1);

    // Narrow, gapless instance.
    din1 = 4'b0110; val1 = 1'b1; push1(4'b0110);
    tick();
    val1 = 1'b0;
    repeat (7) tick();
    @(negedge clk);
    chk("u1_busy_c8", {rdy1, bsy1}, 2'b01);
    tick();
    @(negedge clk);
    chk("u1_ready_c9", {rdy1, en1, bsy1}, 3'b100);

    // Long idle.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_quiet", {d0, en0, bsy0}, 3'b000);
      tick();
    end

    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial frame transmitter that feeds the team's serial sequence detectors.
- Accepts one parallel payload word through a valid/ready handshake.
- Emits on a single-bit line, MSB first: a fixed sync pattern, then the payload, then a programmable run of idle zeros.
- Sits upstream of any serial-pattern detector, as a stimulus source or as a link transmitter.

Parameters:
DATA_W, 8, payload width in bits (>=1)
SYNC_W, 4, sync pattern width in bits (>=1)
SYNC_PAT, 4'b1001, sync pattern, sent MSB first
GAP, 2, idle-zero cycles after each frame (>=0)

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  reset, synchronous, active-low (rst=0 resets on the next posedge)
din  in  DATA_W  payload word
din_valid  in  1  payload offered
din_ready  out  1  transmitter can accept a payload
dout  out  1  serial output bit (registered)
dout_en  out  1  high while dout carries a sync or payload bit
frame_done  out  1  one-cycle pulse on the last payload bit
busy  out  1  high in SYNC, DATA and GAP states

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-low.
- Reset values:
  - state=IDLE; dout=0, dout_en=0, frame_done=0, busy=0.
  - Shift register and counter cleared.
  - din_ready is the decode of state==IDLE, so it reads 1 in the first cycle after rst returns high.
  - Handshakes are ignored while rst=0.
- States are IDLE, SYNC, DATA, GAP.
- IDLE:
  - Outputs: din_ready=1, dout=0, dout_en=0.
  - On a posedge with din_valid&&din_ready: capture din into the shift register, load counter=SYNC_W-1, go to SYNC.
- SYNC:
  - Outputs: dout=SYNC_PAT[cnt], dout_en=1; cnt decrements each cycle.
  - At cnt==0: load cnt=DATA_W-1 and go to DATA.
- DATA:
  - Outputs: dout=shift MSB, dout_en=1; shift left each cycle.
  - At cnt==0: frame_done=1 for that cycle. Next state is GAP (cnt=GAP-1) if GAP>0, else IDLE.
- GAP:
  - Outputs: dout=0, dout_en=0.
  - At cnt==0: go to IDLE.
- Latency:
  - Call the accepting posedge the end of cycle 0. Sync bit MSB appears in cycle 1.
  - Payload MSB appears in cycle SYNC_W+1; last payload bit in cycle SYNC_W+DATA_W.
  - din_ready returns in cycle SYNC_W+DATA_W+GAP+1.
- Minimum spacing: consecutive frames are separated by >=1 idle cycle (the IDLE accept cycle) plus GAP.
- While din_ready=0, din and din_valid are don't-care. Input changes never disturb a frame in flight.
- dout, dout_en and frame_done are driven from registers; no combinational path from din to dout.
- Reset mid-frame: the next cycle is IDLE with all outputs at reset values. No frame_done is emitted and the partial frame is discarded.
- Counter width is $clog2(max(SYNC_W,DATA_W,GAP,1)+1). GAP=0 instantiates no gap logic path.
- Illegal state encodings recover to IDLE with dout=0.

Decomposition:
- Shared package:
  - state enum (IDLE, SYNC, DATA, GAP)
  - default SYNC_PAT constant and SYNC_W, shared with the matching detector
  - counter-width function
- One natural sub-module: piso_shift.
  - Parallel-in/serial-out register, DATA_W wide, with load and shift enables.
  - Instantiated once for the payload.
  - The FSM and counter stay in seq_pattern_tx.

Test Plan:
- Single frame, din=8'hA5, default params, accept in cycle 0:
  - dout in cycles 1..12 = 1,0,0,1,1,0,1,0,0,1,0,1 with dout_en=1.
  - frame_done=1 only in cycle 12.
  - dout=0 and dout_en=0 in cycles 13-14; din_ready=1 in cycle 15.
- din=8'h00:
  - dout = 1,0,0,1 then eight 0s.
  - dout_en high exactly 12 cycles; frame_done in cycle 12.
- Back-to-back frames, din_valid held high with 8'h3C then 8'h81:
  - Second frame's sync MSB appears in cycle 16.
  - din changes during frame 1 do not alter frame 1 bits.
- Reset mid-frame, rst=0 at cycle 6 (payload bit 2):
  - The next cycle shows dout=0, dout_en=0, busy=0, and din_ready=1 once rst=1.
  - No frame_done pulse.
  - A new frame with 8'hFF then transmits correctly.
- GAP=0, DATA_W=4, din=4'b0110:
  - dout cycles 1..8 = 1,0,0,1,0,1,1,0.
  - din_ready=1 in cycle 9.
- din_valid=0 in IDLE for 20 cycles → dout=0, dout_en=0, busy=0 throughout.
